// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enum, data width and opcode legality check.
package alu_pkg;

   localparam int DATA_WIDTH = 16;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_SLT   = 4'h5,
      OP_LOADI = 4'hF
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_e;

   // LOADI counts as legal; it is handled by the sequencer, not the ALU.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= 4'h5) || (op == 4'hF);
   endfunction

endpackage

// File: rtl/alu_16bit.sv
// Combinational 16-bit ALU: ADD/SUB with signed overflow, logic ops, signed SLT.
module alu_16bit
   import alu_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [3:0]  alu_control,
   output logic [15:0] result,
   output logic        zero,
   output logic        overflow
);

   // Result and signed-overflow selection by opcode; unknown codes yield 0.
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (alu_op_e'(alu_control))
         OP_ADD: begin
            result   = a + b;
            overflow = (a[15] == b[15]) && (result[15] != a[15]);
         end
         OP_SUB: begin
            result   = a - b;
            overflow = (a[15] != b[15]) && (result[15] != a[15]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLT:  result = {15'd0, ($signed(a) < $signed(b))};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one sync write port, r0 reads as zero.
module alu_regfile #(
   parameter int NUM_REGS   = 8,
   parameter int REG_AW     = 3,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_AW-1:0]     raddr_a,
   input  logic [REG_AW-1:0]     raddr_b,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic [DATA_WIDTH-1:0] rdata_b,
   input  logic                  we,
   input  logic [REG_AW-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // Writes to r0 are dropped so its storage stays at the cleared value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for alu_16bit: reads operands, drives the ALU, writes back,
// and returns a response per command.
//
//  state | meaning
//  IDLE  | cmd_ready=1, waiting for a command
//  EXEC  | ALU operands presented; result captured and written back at end of cycle
//  RESP  | rsp_valid=1, response held until rsp_ready
module alu_cmd_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 8,
   parameter int REG_AW     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3:0]            cmd_op,
   input  logic [REG_AW-1:0]     cmd_rd,
   input  logic [REG_AW-1:0]     cmd_rs1,
   input  logic [REG_AW-1:0]     cmd_rs2,
   input  logic [DATA_WIDTH-1:0] cmd_imm,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_zero,
   output logic                  rsp_overflow,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [3:0]            alu_control,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   input  logic                  alu_overflow
);

   import alu_pkg::*;

   seq_state_e              state;
   logic [REG_AW-1:0]       rd_q;
   logic [DATA_WIDTH-1:0]   rdata_a;
   logic [DATA_WIDTH-1:0]   rdata_b;
   logic                    rf_we;
   logic [REG_AW-1:0]       rf_waddr;
   logic [DATA_WIDTH-1:0]   rf_wdata;

   assign cmd_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);

   alu_regfile #(
      .NUM_REGS   (NUM_REGS),
      .REG_AW     (REG_AW),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .raddr_a (cmd_rs1),
      .raddr_b (cmd_rs2),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata)
   );

   // Writeback source: immediate on LOADI accept, ALU result during EXEC.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = cmd_rd;
      rf_wdata = cmd_imm;
      if (state == ST_IDLE && cmd_valid && cmd_op == OP_LOADI) begin
         rf_we = 1'b1;
      end else if (state == ST_EXEC) begin
         rf_we    = 1'b1;
         rf_waddr = rd_q;
         rf_wdata = alu_result;
      end
   end

   // Sequencer FSM with registered ALU drive and response fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         rd_q         <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_control  <= '0;
         rsp_data     <= '0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  rd_q <= cmd_rd;
                  if (cmd_op == OP_LOADI) begin
                     rsp_data     <= cmd_imm;
                     rsp_zero     <= (cmd_imm == '0);
                     rsp_overflow <= 1'b0;
                     rsp_err      <= 1'b0;
                     state        <= ST_RESP;
                  end else if (is_legal_op(cmd_op)) begin
                     alu_a       <= rdata_a;
                     alu_b       <= rdata_b;
                     alu_control <= cmd_op;
                     state       <= ST_EXEC;
                  end else begin
                     rsp_data     <= '0;
                     rsp_zero     <= 1'b0;
                     rsp_overflow <= 1'b0;
                     rsp_err      <= 1'b1;
                     state        <= ST_RESP;
                  end
               end
            end
            ST_EXEC: begin
               rsp_data     <= alu_result;
               rsp_zero     <= alu_zero;
               rsp_overflow <= alu_overflow;
               rsp_err      <= 1'b0;
               state        <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
